// File: rtl/fifo_arb_pkg.sv
// Shared helpers for the FIFO write-port arbiter.
// ID width derivation and requester-count range check.
package fifo_arb_pkg;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int id_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic bit num_req_ok(input int n);
    return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotate-priority picker: first set mask bit at or after ptr.
// Pure combinational; wrap is explicit so NUM_REQ need not be 2^n.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    sel,
  output logic               any
);

  // scan farthest-first so the nearest eligible index wins
  always_comb begin
    int idx_i;
    logic [ID_W-1:0] idx;
    sel = '0;
    any = |mask;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_i = int'(ptr) + i;
      if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
      idx = ID_W'(idx_i);
      if (mask[idx]) sel = idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the async FIFO write port.
// Optional packet lock: define FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_W       = id_w(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FULL,
  output logic                          W_INC,
  output logic [DATA_WIDTH-1:0]         WR_DATA,
  output logic [ID_W-1:0]               GRANT_ID
);

  if (!num_req_ok(NUM_REQ)) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ out of range");
  end

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;
  logic [ID_W-1:0]       sel;
  logic [ID_W-1:0]       next_ptr;
  logic [ID_W-1:0]       grant;
  logic                  any;
  logic [ID_W-1:0]       rr_q, rr_d;
  logic [ID_W-1:0]       last_q, last_d;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = REQ_DATA[g*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef FIFO_ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;

  // while locked only the owning requester is eligible
  always_comb begin
    elig = REQ_VALID;
    if (lock_q) elig = REQ_VALID & (NUM_REQ'(1) << lock_id_q);
  end
`else
  logic unused_req_last;
  assign unused_req_last = ^REQ_LAST;

  // every requester competes on every cycle
  always_comb begin
    elig = REQ_VALID;
  end
`endif

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .mask (elig),
    .ptr  (rr_q),
    .sel  (sel),
    .any  (any)
  );

  // strobe, ready and data mux; held index when idle, zero in reset
  always_comb begin
    W_INC     = any & ~FULL & ~RST;
    REQ_READY = '0;
    if (W_INC) REQ_READY[sel] = 1'b1;
    grant    = any ? sel : last_q;
    GRANT_ID = RST ? '0 : grant;
    WR_DATA  = RST ? '0 : data_arr[grant];
    if (int'(sel) == NUM_REQ - 1) next_ptr = '0;
    else next_ptr = sel + ID_W'(1);
  end

  // next state: pointer and lock move only on accepted writes
  always_comb begin
    rr_d   = rr_q;
    last_d = any ? sel : last_q;
`ifdef FIFO_ARB_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (W_INC) begin
      if (REQ_LAST[sel]) begin
        lock_d = 1'b0;
        rr_d   = next_ptr;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = sel;
      end
    end
`else
    if (W_INC) rr_d = next_ptr;
`endif
  end

  // state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q      <= '0;
      last_q    <= '0;
`ifdef FIFO_ARB_LOCK_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
`endif
    end else begin
      rr_q      <= rr_d;
      last_q    <= last_d;
`ifdef FIFO_ARB_LOCK_EN
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`endif
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO between `NUM_REQ` producers in the write clock domain. It selects one valid requester per cycle, drives the FIFO write strobe and data, and returns a per-requester ready. It honours FULL back-pressure with zero-cycle reaction, so the FIFO is never overrun. It sits directly in front of the FIFO's `W_INC`/`WR_DATA`/`FULL` pins and is clocked by the same clock as the FIFO write side.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `DATA_WIDTH`, 8: data word width; must match the FIFO data width
- `CLK`  in  1  write-domain clock; same clock as the FIFO write side
- `RST`  in  1  synchronous, active-high reset
- `REQ_VALID`  in  NUM_REQ  per-requester write request
- `REQ_DATA`  in  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `REQ_LAST`  in  NUM_REQ  end-of-packet marker; used only with `FIFO_ARB_LOCK_EN`
- `REQ_READY`  out  NUM_REQ  one-hot; transfer for requester i occurs when `REQ_VALID[i] & REQ_READY[i]`
- `FULL`  in  1  FIFO full flag
- `W_INC`  out  1  FIFO write strobe
- `WR_DATA`  out  DATA_WIDTH  data of the selected requester
- `GRANT_ID`  out  ID_W  index of the selected requester; ID_W = clog2(NUM_REQ), minimum 1

## Operation
- State registers:
  - `rr_ptr` (ID_W bits): highest-priority index.
  - `lock` (1 bit) and `lock_id` (ID_W bits): used only with `FIFO_ARB_LOCK_EN`.
- Eligible set is `REQ_VALID`, masked to `lock_id` alone while `lock`=1.
- Selection `sel`: first eligible index scanning `rr_ptr`, `rr_ptr`+1, … modulo `NUM_REQ`. Wrap is explicit, so `NUM_REQ` need not be a power of two.
- `any` = eligible set non-empty.
- `W_INC` = `any & ~FULL & ~RST`.
- `REQ_READY[sel]` = `W_INC`; all other ready bits are 0.
- `WR_DATA` = `REQ_DATA` slice of `sel`. `GRANT_ID` = `sel`. Both hold their last-selected value when `any`=0.
- On each accepted transfer (`W_INC`=1), `rr_ptr` <= (`sel`+1) mod `NUM_REQ`. Otherwise `rr_ptr` holds.
- FULL=1 blocks all transfers. Selection still evaluates, but no pointer or lock state changes.
- Fairness: with all requesters continuously valid and FULL=0, grants rotate 0,1,…,NUM_REQ-1,0…

## Timing
- Outputs are combinational from current inputs plus registered state. Latency from `REQ_VALID` to `W_INC` is 0 cycles.
- FULL reaction is 0 cycles: a write is never issued in a cycle where FULL=1.
- Reset (RST=1 sampled at a CLK edge): `rr_ptr`=0, `lock`=0, `lock_id`=0.
- While RST=1: `W_INC`=0, `REQ_READY`=0, `GRANT_ID`=0, `WR_DATA`=0.
- Reset mid-packet drops the lock immediately. After release, arbitration starts from index 0.
- A requester may deassert `REQ_VALID` without a transfer. Its pending data is not consumed and no state changes.
- Simultaneous FULL deassertion and new requests: a transfer may occur in that same cycle.

## Configuration
- `FIFO_ARB_LOCK_EN` defined: packet lock.
  - A transfer with `REQ_LAST[sel]`=0 sets `lock`=1 and `lock_id`=`sel`.
  - While locked, only `lock_id` can be granted, even if its `REQ_VALID` drops.
  - A transfer with `REQ_LAST`=1 clears `lock`.
  - `rr_ptr` advances only on the clearing (LAST) transfer, or on unlocked transfers.
- `FIFO_ARB_LOCK_EN` undefined: `REQ_LAST` is ignored, the lock registers are not built, and every transfer re-arbitrates.

## Structure
- Package `fifo_arb_pkg`: clog2 function, `ID_W` derivation, `NUM_REQ` range check constant.
- Sub-module `fifo_arb_rr_pick`: combinational rotate-priority picker. Inputs are the eligible mask and `rr_ptr`; outputs are `sel` and `any`. It contains no state.
- All registers live in `fifo_wr_arbiter`.

## Test plan
- Reset behaviour: hold RST=1 for 3 cycles with all `REQ_VALID`=1 -> `W_INC`=0, `REQ_READY`=0. First cycle after release -> `GRANT_ID`=0.
- Rotation: `NUM_REQ`=4, all valid, FULL=0, 8 cycles -> `GRANT_ID` sequence 0,1,2,3,0,1,2,3. Each `WR_DATA` equals that requester's data.
- Back-pressure: FULL=1 for cycles 2–4 -> `W_INC`=0 in those cycles. Rotation resumes at the held `rr_ptr` in cycle 5, with no lost or duplicated word.
- Sparse and non-power-of-two: `NUM_REQ`=3, only `REQ_VALID[2]` and `REQ_VALID[0]` asserted -> grants alternate 2,0,2,0, with wrap from 2 to 0.
- Packet lock, with `FIFO_ARB_LOCK_EN`:
  - Requester 1 sends 3 words with LAST on the 3rd, while 0 and 2 are valid -> grants 1,1,1, then 2.
  - Requester 1 drops VALID mid-packet -> no grant to others until it resumes.
- Reset mid-packet: assert RST after word 2 of a locked packet -> lock cleared. After release, requester 0 is granted first.
